// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// collision_detector
//
// Classifies each snake move. On a step pulse the head, the apple and the
// segment count are snapshotted, then the body is scanned one segment per
// cycle looking for a self hit. A single REPORT cycle then decides:
//   wall or self hit -> badColl (sticky until reset / s_reset), state DEAD
//   head on apple    -> goodColl (held until the next accepted step)
//   otherwise        -> normal move
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-low
//   s_reset    in   synchronous game restart, active-high (beats step)
//   step       in   1-cycle pulse, body[0] holds the new head
//   body       in   MAX_LENGTH segments {x[7:4], y[3:0]}, body[0] = head;
//                   must stay stable from step until done (read live in SCAN)
//   length     in   live segment count (clamped to MAX_LENGTH)
//   apple      in   apple position {x, y}
//   goodColl   out  level, last move ate the apple
//   badColl    out  sticky, snake died
//   busy       out  high in SCAN and REPORT
//   done       out  1-cycle pulse, goodColl/badColl valid
//   dbg_state  out  current FSM state (IDLE=0, SCAN=1, REPORT=2, DEAD=3)
//
// Handshake: step is a fire-and-forget pulse. It is accepted only in IDLE;
// a step arriving while busy or in DEAD is dropped, never queued. Every
// accepted step yields exactly one done pulse max(len-1,1)+1 edges later,
// unless a reset aborts the scan (then no done at all).
// ---------------------------------------------------------------------------
module collision_detector #(
    parameter int MAX_LENGTH = 50,
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int LW         = $clog2(MAX_LENGTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_reset,
    input  logic                        step,
    input  logic [MAX_LENGTH-1:0][7:0]  body,
    input  logic [LW-1:0]               length,
    input  logic [7:0]                  apple,
    output logic                        goodColl,
    output logic                        badColl,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [3:0]    X_MAX   = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_MAX   = 4'(GRID_H - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LENGTH);

    state_t        state;
    logic [7:0]    head_q;
    logic [7:0]    apple_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic          hit;

    logic          wall;
    logic [LW:0]   idx_plus1;
    logic          last_scan;
    logic [LW-1:0] len_clamped;

    assign dbg_state = state;

    assign len_clamped = (length > LEN_MAX) ? LEN_MAX : length;

    assign wall = (head_q[7:4] == 4'd0) || (head_q[7:4] == X_MAX) ||
                  (head_q[3:0] == 4'd0) || (head_q[3:0] == Y_MAX);

    // One extra bit so idx+1 cannot wrap. With idx starting at 1 this also
    // makes len_q <= 1 finish SCAN after a single cycle.
    assign idx_plus1 = {1'b0, idx} + (LW + 1)'(1);
    assign last_scan = (idx_plus1 >= {1'b0, len_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            head_q   <= '0;
            apple_q  <= '0;
            len_q    <= '0;
            idx      <= '0;
            hit      <= 1'b0;
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (s_reset) begin
            state    <= IDLE;
            head_q   <= '0;
            apple_q  <= '0;
            len_q    <= '0;
            idx      <= '0;
            hit      <= 1'b0;
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step) begin
                        head_q   <= body[0];
                        apple_q  <= apple;
                        len_q    <= len_clamped;
                        idx      <= LW'(1);
                        hit      <= 1'b0;
                        goodColl <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    if (idx < len_q) begin
                        if (body[idx] == head_q) begin
                            hit <= 1'b1;
                        end
                        idx <= idx + LW'(1);
                    end
                    if (last_scan) begin
                        state <= REPORT;
                    end
                end

                REPORT: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // A death outranks an apple on the same move.
                    if (wall || hit) begin
                        badColl  <= 1'b1;
                        goodColl <= 1'b0;
                        state    <= DEAD;
                    end else begin
                        goodColl <= (head_q == apple_q);
                        state    <= IDLE;
                    end
                end

                DEAD: begin
                    badColl <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_collision_detector
//
// Table of move vectors (length, head, optional self-hit index, apple,
// expected badColl/goodColl and done latency) plus hand-written sequences
// for reset, goodColl hold/clear, DEAD stickiness, dropped steps, reset
// mid-scan and s_reset priority. Expected results are queued when a step is
// driven and popped when done pulses.
// ---------------------------------------------------------------------------
module tb_collision_detector;

    localparam int MAX_LENGTH = 50;
    localparam int LW         = $clog2(MAX_LENGTH + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                       s_reset;
    logic                       step;
    logic [MAX_LENGTH-1:0][7:0] body;
    logic [LW-1:0]              length;
    logic [7:0]                 apple;
    logic                       goodColl;
    logic                       badColl;
    logic                       busy;
    logic                       done;
    logic [1:0]                 dbg_state;

    collision_detector #(
        .MAX_LENGTH (MAX_LENGTH),
        .GRID_W     (16),
        .GRID_H     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_reset   (s_reset),
        .step      (step),
        .body      (body),
        .length    (length),
        .apple     (apple),
        .goodColl  (goodColl),
        .badColl   (badColl),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];   // {badColl, goodColl} per accepted step
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int         len;
        logic [7:0] head;
        int         hit_at;   // 0 = no self hit placed
        logic [7:0] apl;
        logic       bad;
        logic       good;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load_snake(input int len, input logic [7:0] head, input int hit_at,
                              input logic [7:0] apl);
        logic [7:0] cand;
        body[0] = head;
        for (int i = 1; i < MAX_LENGTH; i++) begin
            cand = 8'($urandom_range(0, 255));
            if (cand == head) cand = cand ^ 8'h01;
            body[i] = cand;
        end
        if (hit_at > 0 && hit_at < MAX_LENGTH) body[hit_at] = head;
        length = LW'(len);
        apple  = apl;
    endtask

    // Leaves the bench at the falling edge after edge 0 (the accepting edge).
    task automatic do_step(input logic push, input logic [1:0] exp);
        step = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        step = 1'b0;
    endtask

    // Waits for done; lat counts rising edges from the current falling edge.
    task automatic wait_done(input string name, input int lat);
        logic [1:0] e;
        bit seen;
        seen = 0;
        for (int n = 1; n <= 120 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({name, "_latency"}, n, lat);
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected_done"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_badColl"}, badColl, e[1]);
                    check({name, "_goodColl"}, goodColl, e[0]);
                end
            end
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic pulse_s_reset();
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        s_reset = 1'b0;
        step    = 1'b0;
        body    = '0;
        length  = '0;
        apple   = '0;

        //          len head   hit apple  bad good lat
        vecs[0]  = '{4,  8'h55, 0,  8'h99, 0, 0, 4};   // normal move
        vecs[1]  = '{3,  8'h83, 0,  8'h83, 0, 1, 3};   // apple eaten
        vecs[2]  = '{6,  8'h77, 5,  8'h11, 1, 0, 6};   // self hit on last segment
        vecs[3]  = '{1,  8'hF7, 0,  8'h00, 1, 0, 2};   // len 1, right wall
        vecs[4]  = '{3,  8'h04, 0,  8'h04, 1, 0, 3};   // left wall beats apple
        vecs[5]  = '{0,  8'h55, 0,  8'h55, 0, 1, 2};   // len 0, single scan cycle
        vecs[6]  = '{2,  8'h3C, 1,  8'h00, 1, 0, 2};   // self hit on body[1]
        vecs[7]  = '{10, 8'h5E, 0,  8'h5E, 0, 1, 10};  // y=14 is inside grid
        vecs[8]  = '{5,  8'h6F, 0,  8'h00, 1, 0, 5};   // bottom wall y=15
        vecs[9]  = '{63, 8'h44, 0,  8'h12, 0, 0, 50};  // length clamped to 50
        vecs[10] = '{8,  8'h44, 9,  8'h00, 0, 0, 8};   // match beyond length ignored
        vecs[11] = '{50, 8'h44, 49, 8'h00, 1, 0, 50};  // hit on deepest segment

        // Reset held low with step toggling: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            step = ~step;
            @(negedge clk);
            check("reset_outputs", {goodColl, badColl, busy, done}, 4'b0000);
            check("reset_state", dbg_state, 2'd0);
        end
        step  = 1'b0;
        reset = 1'b1;
        idle(2);
        check("post_reset_state", dbg_state, 2'd0);

        // Table-driven moves, each from a fresh game.
        for (int v = 0; v < 12; v++) begin
            pulse_s_reset();
            check($sformatf("vec%0d_pre_state", v), dbg_state, 2'd0);
            check($sformatf("vec%0d_pre_out", v), {goodColl, badColl, busy, done}, 4'b0000);
            idle($urandom_range(0, 3));
            load_snake(vecs[v].len, vecs[v].head, vecs[v].hit_at, vecs[v].apl);
            do_step(1'b1, {vecs[v].bad, vecs[v].good});
            check($sformatf("vec%0d_busy", v), busy, 1);
            wait_done($sformatf("vec%0d", v), vecs[v].lat);
            check($sformatf("vec%0d_busy_after", v), busy, 0);
            check($sformatf("vec%0d_state_after", v), dbg_state, vecs[v].bad ? 2'd3 : 2'd0);
        end

        // goodColl holds after eating, then clears on the next accepted step.
        pulse_s_reset();
        load_snake(3, 8'h83, 0, 8'h83);
        do_step(1'b1, 2'b01);
        wait_done("apple", 3);
        idle(3);
        check("apple_hold", goodColl, 1);
        load_snake(3, 8'h84, 0, 8'h83);
        do_step(1'b1, 2'b00);
        check("apple_clear_on_step", goodColl, 0);
        wait_done("apple_next", 3);

        // DEAD is sticky and ignores steps until s_reset.
        pulse_s_reset();
        load_snake(6, 8'h77, 5, 8'h00);
        do_step(1'b1, 2'b10);
        wait_done("dead", 6);
        for (int i = 0; i < 8; i++) begin
            step = (i % 3 == 0);
            @(negedge clk);
            check("dead_no_done", done, 0);
            check("dead_no_busy", busy, 0);
            check("dead_sticky", badColl, 1);
        end
        step = 1'b0;
        pulse_s_reset();
        check("dead_cleared", badColl, 0);
        check("dead_cleared_state", dbg_state, 2'd0);

        // A step during SCAN is dropped: exactly one done.
        load_snake(6, 8'h55, 0, 8'h00);
        do_step(1'b1, 2'b00);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done("abuse_step", 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abuse_single_done", done, 0);
        end
        check("abuse_queue_empty", exp_q.size(), 0);

        // Async reset mid-SCAN aborts without a done pulse.
        load_snake(10, 8'h55, 0, 8'h55);
        do_step(1'b0, 2'b00);
        idle(3);
        reset = 1'b0;
        #1;
        check("midscan_reset_state", dbg_state, 2'd0);
        check("midscan_reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("midscan_no_done", done, 0);
        end

        // s_reset wins over a simultaneous step.
        load_snake(4, 8'h55, 0, 8'h00);
        s_reset = 1'b1;
        step    = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        step    = 1'b0;
        check("sreset_beats_step_state", dbg_state, 2'd0);
        check("sreset_beats_step_busy", busy, 0);
        idle(6);
        check("sreset_beats_step_no_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
